// File: rtl/example_hmc_fifo_prefetch_rd.sv
// example_hmc_fifo_prefetch_rd: first-word-fall-through prefetch buffer on the sync FIFO controller read port
module example_hmc_fifo_prefetch_rd #(
  parameter int FFDATA_W  = 512,
  parameter int PF_DEPTH  = 4,
  parameter int PF_ADDR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_en,
  input  logic                ff_empty,
  input  logic                do_vld,
  input  logic [FFDATA_W-1:0] mem_rdt,
  output logic                do_rd,
  output logic                dout_vld,
  output logic [FFDATA_W-1:0] dout,
  input  logic                dout_rdy,
  output logic [PF_ADDR_W:0]  pf_cnt,
  output logic [PF_ADDR_W:0]  rd_outst,
  output logic                err_unexp_vld,
  output logic                err_pf_ovflow
);
  localparam logic [PF_ADDR_W:0]   FULL  = (PF_ADDR_W+1)'(PF_DEPTH);
  localparam logic [PF_ADDR_W+1:0] LIMIT = (PF_ADDR_W+2)'(PF_DEPTH);
  localparam logic [PF_ADDR_W-1:0] IDX1  = PF_ADDR_W'(1);
  localparam logic [PF_ADDR_W:0]   CNT1  = (PF_ADDR_W+1)'(1);
  logic [FFDATA_W-1:0]  buf_q [PF_DEPTH];
  logic [PF_ADDR_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [PF_ADDR_W:0]   cnt_q, cnt_d, outst_q, outst_d;
  logic [PF_ADDR_W+1:0] inflight;
  logic                 eu_q, eu_d, eo_q, eo_d, wr, pop;
  always_comb begin
    inflight = {1'b0, outst_q} + {1'b0, cnt_q};
    do_rd    = ~rst & cfg_en & ~ff_empty & (inflight < LIMIT);
    dout_vld = cnt_q != '0;
    wr       = do_vld & (cnt_q != FULL);
    pop      = dout_vld & dout_rdy;
    wr_idx_d = wr ? wr_idx_q + IDX1 : wr_idx_q;
    rd_idx_d = pop ? rd_idx_q + IDX1 : rd_idx_q;
    cnt_d    = (wr & ~pop) ? cnt_q + CNT1 : (pop & ~wr) ? cnt_q - CNT1 : cnt_q;
    outst_d  = (do_rd & ~do_vld) ? outst_q + CNT1 :
               (do_vld & ~do_rd & (outst_q != '0)) ? outst_q - CNT1 : outst_q;
    eu_d     = eu_q | (do_vld & (outst_q == '0));
    eo_d     = eo_q | (do_vld & (cnt_q == FULL));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
      outst_q  <= '0;
      eu_q     <= 1'b0;
      eo_q     <= 1'b0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
      outst_q  <= outst_d;
      eu_q     <= eu_d;
      eo_q     <= eo_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) buf_q[wr_idx_q] <= mem_rdt;
  end
  assign dout          = buf_q[rd_idx_q];
  assign pf_cnt        = cnt_q;
  assign rd_outst      = outst_q;
  assign err_unexp_vld = eu_q;
  assign err_pf_ovflow = eo_q;
endmodule

// File: tb/tb_example_hmc_fifo_prefetch_rd.sv
// tb_example_hmc_fifo_prefetch_rd: FIFO controller model drives the DUT; a monitor scoreboards the output stream
module tb_example_hmc_fifo_prefetch_rd;
  localparam int W = 64, D = 4, AW = 2;
  logic clk = 0, rst = 1, cfg_en = 0, ff_empty = 1, do_vld = 0, dout_rdy = 0;
  logic [W-1:0] mem_rdt = '0, dout;
  logic do_rd, dout_vld, err_unexp_vld, err_pf_ovflow;
  logic [AW:0] pf_cnt, rd_outst;
  int n_cmp = 0, n_bad = 0;
  typedef struct {int due; logic [W-1:0] d;} ret_t;
  ret_t ret[$];
  logic [W-1:0] fifo[$], exp_q[$];
  int cyc = 0, last_due = 0, lat_fix = 0, rdy_mode = 0, n_rd = 0, first_rd = -1, last_rd_cyc = -1;
  logic rdy_fix = 0, cfg_rand = 0, cfg_fix = 1, inj = 0, rd_seen = 0;
  int m_cnt = 0, m_outst = 0;
  logic m_eu = 0, m_eo = 0, stall = 0;
  logic [W-1:0] stall_d = '0;

  example_hmc_fifo_prefetch_rd #(.FFDATA_W(W), .PF_DEPTH(D), .PF_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .ff_empty(ff_empty), .do_vld(do_vld),
    .mem_rdt(mem_rdt), .do_rd(do_rd), .dout_vld(dout_vld), .dout(dout), .dout_rdy(dout_rdy),
    .pf_cnt(pf_cnt), .rd_outst(rd_outst), .err_unexp_vld(err_unexp_vld), .err_pf_ovflow(err_pf_ovflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [W-1:0] a, logic [W-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Monitor: occupancy/outstanding counted from observed traffic, data checked against issue order
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      m_cnt = 0; m_outst = 0; m_eu = 0; m_eo = 0; stall = 0;
    end else begin
      chk("pf_cnt", W'(pf_cnt), W'(m_cnt));
      chk("rd_outst", W'(rd_outst), W'(m_outst));
      chk("dout_vld", W'(dout_vld), W'(m_cnt != 0));
      chk("do_rd", W'(do_rd), W'(cfg_en && !ff_empty && (m_cnt + m_outst < D)));
      chk("err_unexp_vld", W'(err_unexp_vld), W'(m_eu));
      chk("err_pf_ovflow", W'(err_pf_ovflow), W'(m_eo));
      if (stall && dout_vld) chk("dout_stable", dout, stall_d);
      if (dout_vld && dout_rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL dout_extra: got %h expected no word", dout);
        end else chk("dout", dout, exp_q.pop_front());
      end
      if (do_vld && m_outst == 0) m_eu = 1;
      if (do_vld && m_cnt == D) m_eo = 1;
      m_cnt = m_cnt + ((do_vld && m_cnt < D) ? 1 : 0) - ((m_cnt != 0 && dout_rdy) ? 1 : 0);
      if (do_rd && !do_vld) m_outst++;
      else if (do_vld && !do_rd && m_outst > 0) m_outst--;
      stall = dout_vld && !dout_rdy;
      stall_d = dout;
    end
  end

  // One clock of the FIFO controller model: drive inputs at negedge, act on do_rd at the next posedge
  task automatic cycle();
    @(negedge clk);
    cyc++;
    do_vld = 0;
    mem_rdt = '0;
    if (ret.size() > 0 && ret[0].due <= cyc) begin
      do_vld = 1;
      mem_rdt = ret[0].d;
      void'(ret.pop_front());
    end
    if (inj) begin
      do_vld = 1;
      mem_rdt = {$urandom, $urandom};
      inj = 0;
    end
    ff_empty = (fifo.size() == 0);
    cfg_en = cfg_rand ? ($urandom_range(0, 3) != 0) : cfg_fix;
    dout_rdy = rdy_mode == 0 ? rdy_fix : rdy_mode == 1 ? ~dout_rdy : 1'($urandom_range(0, 1));
    #1;
    rd_seen = do_rd;
    if (do_rd && fifo.size() > 0) begin
      ret_t r;
      r.due = cyc + (lat_fix > 0 ? lat_fix : int'($urandom_range(1, 4)));
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      r.d = fifo.pop_front();
      ret.push_back(r);
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
      last_rd_cyc = cyc;
    end
  endtask

  task automatic load(int n, bit seq);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] w;
      w = seq ? W'(i) : {$urandom, $urandom};
      fifo.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic drain(int lim);
    int k = 0;
    while ((fifo.size() != 0 || ret.size() != 0 || exp_q.size() != 0) && k < lim) begin
      cycle();
      k++;
    end
    cycle();
    cycle();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d words left after %0d cycles, required 0", exp_q.size(), lim);
    end
  endtask

  task automatic chk_zero(string n);
    chk({n, "_pf_cnt"}, W'(pf_cnt), '0);
    chk({n, "_rd_outst"}, W'(rd_outst), '0);
    chk({n, "_do_rd"}, W'(do_rd), '0);
    chk({n, "_dout_vld"}, W'(dout_vld), '0);
    chk({n, "_err_unexp"}, W'(err_unexp_vld), '0);
    chk({n, "_err_ovf"}, W'(err_pf_ovflow), '0);
  endtask

  // Asserted between clock edges so the zeroing must be asynchronous
  task automatic do_reset();
    #2;
    rst = 1;
    #1;
    chk_zero("async_rst");
    fifo.delete();
    ret.delete();
    exp_q.delete();
    last_due = 0;
    cycle();
    cycle();
    #3;
    rst = 0;
  endtask

  initial begin
    int k;
    cycle();
    cycle();
    chk_zero("reset");
    #3;
    rst = 0;
    lat_fix = 2; rdy_mode = 0; rdy_fix = 0; cfg_fix = 1;
    load(10, 1);
    n_rd = 0; first_rd = -1;
    repeat (15) cycle();
    chk("prefill_rd_count", W'(n_rd), 4);
    chk("prefill_rd_span", W'(last_rd_cyc - first_rd), 3);
    chk("prefill_pf_cnt", W'(pf_cnt), 4);
    chk("prefill_rd_outst", W'(rd_outst), 0);
    rdy_fix = 1;
    drain(100);
    chk_zero("stream_end");
    lat_fix = 0; rdy_mode = 1;
    load(12, 0);
    drain(200);
    rdy_mode = 0; rdy_fix = 1; n_rd = 0;
    repeat (6) cycle();
    chk("empty_no_rd", W'(n_rd), 0);
    load(1, 0);
    cycle();
    chk("empty_fall_rd", W'(rd_seen), 1);
    drain(50);
    rdy_fix = 0;
    load(6, 0);
    repeat (2) cycle();
    cfg_fix = 0;
    n_rd = 0;
    repeat (8) cycle();
    chk("cfg_off_no_rd", W'(n_rd), 0);
    cfg_fix = 1; rdy_fix = 1;
    drain(100);
    cfg_rand = 1; rdy_mode = 2;
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) load(int'($urandom_range(1, 6)), 0);
      cycle();
    end
    cfg_rand = 0; cfg_fix = 1;
    drain(300);
    chk_zero("random_end");
    rdy_mode = 0; rdy_fix = 0;
    inj = 1;
    cycle();
    cycle();
    chk("err_unexp_set", W'(err_unexp_vld), 1);
    repeat (3) cycle();
    chk("err_unexp_held", W'(err_unexp_vld), 1);
    repeat (3) begin
      inj = 1;
      cycle();
    end
    cycle();
    chk("inj_pf_full", W'(pf_cnt), 4);
    chk("err_ovf_clear", W'(err_pf_ovflow), 0);
    inj = 1;
    cycle();
    cycle();
    chk("err_ovf_set", W'(err_pf_ovflow), 1);
    chk("ovf_pf_cnt", W'(pf_cnt), 4);
    do_reset();
    lat_fix = 3;
    load(10, 0);
    k = 0;
    while (!(pf_cnt == 3 && rd_outst == 1) && k < 50) begin
      cycle();
      k++;
    end
    n_cmp++;
    if (k >= 50) begin
      n_bad++;
      $display("FAIL reach_3_1: got pf_cnt %0d rd_outst %0d expected 3 and 1", pf_cnt, rd_outst);
    end
    do_reset();
    inj = 1;
    cycle();
    cycle();
    chk("stale_vld_err", W'(err_unexp_vld), 1);
    do_reset();
    lat_fix = 0; rdy_fix = 1;
    load(8, 0);
    drain(100);
    chk_zero("resume_end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
